// File: rtl/a2d_arbiter.sv
// Round-robin arbiter and sequencer sharing one A2D converter between NUM_REQ requesters.
// Latches the winner's channel, runs one conversion and returns result/done, with a watchdog abort.
module a2d_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CH_W    = 3,
  parameter int RES_W   = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*CH_W-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [RES_W-1:0]        res,
  output logic                    timeout,
  output logic                    err_sticky,
  input  logic                    clr_err,
  output logic                    busy,
  output logic                    a2d_strt_cnv,
  output logic [CH_W-1:0]         a2d_chnnl,
  input  logic                    a2d_cnv_cmplt,
  input  logic [RES_W-1:0]        a2d_res,
  output logic [1:0]              state_dbg
);

  // Handshake: req[i] is a level request that must stay high until gnt[i] pulses;
  // gnt[i] is the accept, and done[i] later closes the transaction (completion or abort).

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [PTR_W-1:0]   LAST    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CONV  = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] winner;
  logic             found;
  logic [CNT_W-1:0] cnt;

  assign state_dbg = state;

  // Scan downward so the requester closest above ptr (with wrap) is the last one kept.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] cand;
    winner = ptr;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      gnt          <= '0;
      done         <= '0;
      res          <= '0;
      timeout      <= 1'b0;
      err_sticky   <= 1'b0;
      busy         <= 1'b0;
      a2d_strt_cnv <= 1'b0;
      a2d_chnnl    <= '0;
    end else begin
      gnt          <= '0;
      done         <= '0;
      timeout      <= 1'b0;
      a2d_strt_cnv <= 1'b0;
      if (clr_err) err_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner        <= winner;
            a2d_chnnl    <= req_chnnl[winner*CH_W +: CH_W];
            gnt          <= ONE << winner;
            a2d_strt_cnv <= 1'b1;
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          // A completion on the final watchdog count still wins over the abort.
          if (a2d_cnv_cmplt) begin
            res   <= a2d_res;
            done  <= ONE << owner;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            done       <= ONE << owner;
            timeout    <= 1'b1;
            err_sticky <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: vector table for arbitration order plus hand sequences
// for early completion, owner drop, reset mid-conversion and the watchdog.
module tb_a2d_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int CH_W       = 3;
  localparam int RES_W      = 12;
  localparam int TIMEOUT    = 16;
  localparam int WD_TIMEOUT = 8;
  localparam int NV         = 13;
  localparam logic [1:0] CONV_ST = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*CH_W-1:0] req_chnnl = '0;
  logic                    clr_err = 1'b0;
  logic                    a2d_cnv_cmplt = 1'b0;
  logic [RES_W-1:0]        a2d_res = '0;

  logic [NUM_REQ-1:0] gnt, done, w_gnt, w_done;
  logic [RES_W-1:0]   res, w_res;
  logic               timeout, err_sticky, busy, a2d_strt_cnv;
  logic               w_timeout, w_err_sticky, w_busy, w_strt_cnv;
  logic [CH_W-1:0]    a2d_chnnl, w_chnnl;
  logic [1:0]         state_dbg, w_state_dbg;

  a2d_arbiter #(.NUM_REQ(NUM_REQ), .CH_W(CH_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl), .gnt(gnt), .done(done),
    .res(res), .timeout(timeout), .err_sticky(err_sticky), .clr_err(clr_err), .busy(busy),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl), .a2d_cnv_cmplt(a2d_cnv_cmplt),
    .a2d_res(a2d_res), .state_dbg(state_dbg)
  );

  a2d_arbiter #(.NUM_REQ(NUM_REQ), .CH_W(CH_W), .RES_W(RES_W), .TIMEOUT(WD_TIMEOUT)) dut_wd (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl), .gnt(w_gnt), .done(w_done),
    .res(w_res), .timeout(w_timeout), .err_sticky(w_err_sticky), .clr_err(clr_err), .busy(w_busy),
    .a2d_strt_cnv(w_strt_cnv), .a2d_chnnl(w_chnnl), .a2d_cnv_cmplt(a2d_cnv_cmplt),
    .a2d_res(a2d_res), .state_dbg(w_state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {cycle[15:0], done, res, timeout}
  logic [31:0]      exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             mon_sel = 1'b0;
  logic [RES_W-1:0] model_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [NUM_REQ-1:0] md;
  logic [RES_W-1:0]   mr;
  logic               mt;
  always @(negedge clk) begin
    if (rst_n) begin
      md = mon_sel ? w_done : done;
      mr = mon_sel ? w_res : res;
      mt = mon_sel ? w_timeout : timeout;
      if (md != '0) begin
        if (exp_q.size() == 0) check("done_unexpected", {16'(cyc), md, mr, mt}, 32'd0);
        else check("done_pkt", {16'(cyc), md, mr, mt}, exp_q.pop_front());
      end else if (mt) begin
        check("timeout_alone", 32'(mt), 32'd0);
      end
    end
  end

  // driver tasks: drive point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    a2d_cnv_cmplt = 1'b0;
    clr_err = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    model_res = '0;
    step();
  endtask

  task automatic complete(input int idx, input logic [RES_W-1:0] rv);
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    eg[idx] = 1'b1;
    a2d_cnv_cmplt = 1'b1;
    a2d_res = rv;
    exp_q.push_back({16'(cyc + 1), eg, rv, 1'b0});
    model_res = rv;
    step();
    a2d_cnv_cmplt = 1'b0;
    a2d_res = RES_W'($urandom_range(0, 4095));
  endtask

  task automatic do_txn(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*CH_W-1:0] chs,
                        input int exp_idx, input int lat, input logic [RES_W-1:0] rv,
                        input logic drop);
    logic [NUM_REQ-1:0] eg;
    logic [CH_W-1:0]    ech;
    int                 bad;
    eg = '0;
    eg[exp_idx] = 1'b1;
    ech = chs[exp_idx*CH_W +: CH_W];
    req = mask;
    req_chnnl = chs;
    step();
    check("gnt", {29'd0, gnt, a2d_strt_cnv, busy}, {29'd0, eg, 2'b11});
    check("chnnl_start", 32'(a2d_chnnl), 32'(ech));
    if (drop) req = '0;
    bad = 0;
    for (int i = 0; i < lat; i++) begin
      step();
      if (a2d_chnnl !== ech || gnt !== '0 || a2d_strt_cnv !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("chnnl_hold", bad, 0);
    complete(exp_idx, rv);
    req = '0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      step();
      i++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0]      mask;
    int                      exp_idx;
    int                      lat;
    logic [NUM_REQ*CH_W-1:0] chs;
    logic [RES_W-1:0]        rv;
  } vec_t;

  vec_t vecs[NV];
  logic [NUM_REQ-1:0] masks[NV] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                                     3'b110, 3'b011, 3'b101, 3'b100, 3'b001, 3'b010, 3'b111};
  int idxs[NV] = '{0, 1, 2, 0, 1, 2, 1, 0, 2, 2, 0, 1, 2};

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [RES_W-1:0] rv;

    for (int i = 0; i < NV; i++) begin
      vecs[i].mask    = masks[i];
      vecs[i].exp_idx = idxs[i];
      vecs[i].lat     = $urandom_range(1, 8);
      vecs[i].chs     = (NUM_REQ*CH_W)'($urandom_range(0, 511));
      vecs[i].rv      = RES_W'($urandom_range(0, 4095));
    end

    do_reset();
    check("reset_state", 32'({gnt, done, timeout, err_sticky, busy, a2d_strt_cnv,
                              a2d_chnnl, res, state_dbg}), 32'd0);

    // arbitration order, requests held continuously through each transaction
    for (int i = 0; i < NV; i++)
      do_txn(vecs[i].mask, vecs[i].chs, vecs[i].exp_idx, vecs[i].lat, vecs[i].rv, 1'b0);
    drain();

    // single request: req[1] ch 4, completion at T+10, done at T+11
    do_txn(3'b010, 9'b000_100_000, 1, 9, 12'hA5C, 1'b1);
    drain();
    check("single_res", 32'(res), 32'h0A5C);

    // completion in IDLE and in START is ignored
    a2d_cnv_cmplt = 1'b1;
    a2d_res = 12'h111;
    step();
    step();
    check("idle_cmplt", {19'd0, busy, res}, {19'd0, 1'b0, model_res});
    req = 3'b001;
    req_chnnl = 9'o765;
    step();
    check("early_gnt", 32'(gnt), 32'b001);
    req = '0;
    step();
    check("start_cmplt", {17'd0, state_dbg, done, res}, {17'd0, CONV_ST, 3'b000, model_res});
    a2d_cnv_cmplt = 1'b0;
    step();
    complete(0, RES_W'($urandom_range(0, 4095)));

    // owner drops its request mid-conversion
    req = 3'b001;
    step();
    check("drop_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    repeat (3) step();
    complete(0, RES_W'($urandom_range(0, 4095)));
    drain();

    // reset during CONV (owner 1 leaves ptr at 2 before the reset)
    req = 3'b010;
    req_chnnl = 9'o123;
    step();
    req = '0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({gnt, done, timeout, err_sticky, busy, a2d_strt_cnv,
                              a2d_chnnl, res, state_dbg}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    model_res = '0;
    a2d_cnv_cmplt = 1'b1;
    a2d_res = 12'hFFF;
    step();
    step();
    a2d_cnv_cmplt = 1'b0;
    check("late_cmplt", {19'd0, busy, res}, 32'd0);
    do_txn(3'b111, 9'o654, 0, 3, 12'h3C3, 1'b1);
    do_txn(3'b100, 9'o654, 2, 2, 12'h0F0, 1'b1);
    drain();

    // watchdog on the TIMEOUT=8 instance
    rst_n = 1'b0;
    mon_sel = 1'b1;
    do_reset();
    req = 3'b001;
    k = cyc;
    step();
    check("wd_gnt", 32'(w_gnt), 32'b001);
    req = '0;
    exp_q.push_back({16'(k + WD_TIMEOUT + 2), 3'b001, model_res, 1'b1});
    repeat (WD_TIMEOUT) step();
    check("wd_early", {29'd0, w_done, w_timeout, w_err_sticky}, 32'd0);
    step();
    check("wd_sticky", {19'd0, w_err_sticky, w_res}, {19'd0, 1'b1, model_res});
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("wd_clr", 32'(w_err_sticky), 32'd0);

    // clear held while a new timeout fires: the set wins, then the clear applies
    clr_err = 1'b1;
    req = 3'b001;
    k = cyc;
    step();
    req = '0;
    exp_q.push_back({16'(k + WD_TIMEOUT + 2), 3'b001, model_res, 1'b1});
    repeat (WD_TIMEOUT + 1) step();
    check("wd_set_wins", 32'(w_err_sticky), 32'd1);
    step();
    clr_err = 1'b0;
    check("wd_clr_after", 32'(w_err_sticky), 32'd0);

    // completion on the final count beats the abort
    req = 3'b001;
    step();
    req = '0;
    repeat (WD_TIMEOUT) step();
    rv = RES_W'($urandom_range(0, 4095));
    complete(0, rv);
    check("wd_coincide", {19'd0, w_err_sticky, w_res}, {19'd0, 1'b0, rv});
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/a2d_arbiter.md
# a2d_arbiter

Round-robin arbiter and sequencer that shares the single A2D converter interface between up to NUM_REQ requesters. Requesters include the motion controller's IR sensor sweep, the battery monitor and the command-processor diagnostic reads. The block latches the winning request, drives `strt_cnv`/`chnnl` to the A2D front end, and waits for `cnv_cmplt`. It then returns the result and a completion pulse to the owner, with a watchdog that recovers from a converter that never completes. It sits between the requesters and the A2D/SPI interface block.

## Interface
- NUM_REQ, default 3: number of requesters (2..8).
- CH_W, default 3: channel select width.
- RES_W, default 12: conversion result width.
- TIMEOUT, default 1024: maximum CONV cycles before watchdog abort (≥2).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  level request per requester; held until its `gnt` pulse.
- req_chnnl  in  NUM_REQ*CH_W  channel for requester i in bits [i*CH_W +: CH_W].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: request i accepted.
- done  out  NUM_REQ  one-hot, one-cycle pulse: owner's conversion finished or aborted.
- res  out  RES_W  last captured result; held until the next successful completion.
- timeout  out  1  one-cycle pulse coincident with an aborting `done`.
- err_sticky  out  1  set on any timeout, cleared by `clr_err`.
- clr_err  in  1  synchronous clear of `err_sticky`.
- busy  out  1  high in START and CONV.
- a2d_strt_cnv  out  1  one-cycle conversion start to the A2D front end.
- a2d_chnnl  out  CH_W  channel to convert; stable from START through end of CONV.
- a2d_cnv_cmplt  in  1  conversion complete from the A2D front end.
- a2d_res  in  RES_W  conversion result; valid when `a2d_cnv_cmplt` is high.

## Operation
- States: IDLE, START, CONV.
- IDLE
  - If any `req` is high, select the winner by round-robin, searching upward from `ptr` with wrap.
  - Latch `owner` and `req_chnnl[owner]`, then go to START.
  - `a2d_cnv_cmplt` is ignored in IDLE.
- START (exactly 1 cycle)
  - `gnt[owner]`=1, `a2d_strt_cnv`=1, `a2d_chnnl`=latched channel.
  - `ptr` ← (owner+1) mod NUM_REQ.
  - Watchdog counter ← 0.
  - Go to CONV.
- CONV
  - Counter increments each cycle.
  - On `a2d_cnv_cmplt`=1: `res` ← `a2d_res`, `done[owner]` pulses next cycle, go to IDLE.
  - If counter == TIMEOUT-1 and `a2d_cnv_cmplt`=0: `done[owner]` and `timeout` pulse next cycle, `err_sticky` ← 1, `res` unchanged, go to IDLE.
  - If `cnv_cmplt` and the timeout condition occur in the same cycle, the completion wins and no timeout is raised.
- Deasserting `req[owner]` during START or CONV does not abort the conversion.
- Any `req` still high when `done` fires is arbitrated normally in the following IDLE cycle.
- Channel wiring is pass-through; the block does not remap channels.
- `clr_err` and a simultaneous new timeout: set wins.
- Reset values:
  - State IDLE, `ptr`=0, owner=0.
  - `gnt`, `done`, `timeout`, `busy`, `a2d_strt_cnv`, `err_sticky` = 0.
  - `a2d_chnnl`=0, `res`=0.
  - An in-flight conversion is abandoned on reset, and a late `cnv_cmplt` after reset is ignored.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- `req` sampled high in IDLE at cycle T:
  - `gnt`, `a2d_strt_cnv` and `busy` are high at T+1.
  - CONV begins at T+2.
- `a2d_cnv_cmplt` sampled high at cycle C (≥ T+2): `done`/`res` are valid at C+1, and the block is in IDLE at C+1.
- Back-to-back turnaround: a pending `req` at C+1 gives the next `gnt` at C+2. Minimum request-to-request spacing is 3 cycles plus converter latency.
- Timeout: with no completion, `done`+`timeout` assert at T+2+TIMEOUT.
- `res` changes only on the cycle `done` asserts after a successful completion.

## Test plan
- **Single request.** NUM_REQ=3; `req[1]`=1, ch 4 at T; `cnv_cmplt` with res 0xA5C at T+10. Required:
  - `gnt`=3'b010 and `a2d_strt_cnv`=1 at T+1.
  - `a2d_chnnl`=4 through T+10.
  - `done`=3'b010 and `res`=0xA5C at T+11.
- **Round-robin fairness.** All three `req` held high continuously. Grants occur in order 0, 1, 2, 0, 1, 2, with no requester granted twice before the others.
- **Early completion ignored.** `cnv_cmplt` driven high in IDLE and in the START cycle. Required: no `done` and no `res` change; completion is honoured only from CONV.
- **Watchdog.** TIMEOUT=8, `cnv_cmplt` never asserted. Required:
  - `done`+`timeout` at T+10.
  - `err_sticky`=1 and `res` unchanged.
  - `clr_err` clears `err_sticky`.
  - A completion that coincides with the final count instead gives `done`, no `timeout`, and updates `res`.
- **Owner drops request mid-conversion.** `req[0]` deasserted during CONV. The conversion still completes and `done[0]` pulses.
- **Reset mid-operation.** `rst_n` pulsed low during CONV. Required:
  - All outputs return to reset values.
  - `ptr`=0.
  - A later `cnv_cmplt` produces no `done`.
  - A subsequent `req[2]` is granted normally.
